// File: rtl/rr_reconf_ctrl.sv
// Swap controller for one reconfigurable region: quiesce, isolate, configure, reset, release.
// Latency: accept to done is 5+RST_CYCLES cycles when the RR and loader each answer one cycle after being asked; all outputs registered.
// Backpressure: req_ready is high only in IDLE; requests seen while busy are dropped, not queued.
module rr_reconf_ctrl #(
    parameter int RRID_W      = 2,
    parameter int INIT_RRID   = 0,
    parameter int ACK_TIMEOUT = 1023,
    parameter int RST_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic [RRID_W-1:0] req_rrid,
    output logic              req_ready,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [RRID_W-1:0] cur_rrid,
    output logic              rc_reqn,
    input  logic              rc_ackn,
    output logic              is_reconfn,
    output logic              rr_rstn,
    output logic              cfg_start,
    output logic [RRID_W-1:0] cfg_rrid,
    input  logic              cfg_done,
    input  logic              cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_ISOLATE,
        S_CONFIG,
        S_RRRESET,
        S_RELEASE,
        S_ABORT,
        S_ABORT_CFG
    } state_t;

    localparam logic [15:0]       ACK_LIM  = 16'(ACK_TIMEOUT);
    localparam logic [7:0]        RST_LIM  = 8'(RST_CYCLES - 1);
    localparam logic [RRID_W-1:0] RRID_RST = RRID_W'(INIT_RRID);

    state_t            state_q, state_d;
    logic [15:0]       ack_cnt_q, ack_cnt_d, ack_nxt;
    logic [7:0]        rst_cnt_q, rst_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [RRID_W-1:0] cur_rrid_q, cur_rrid_d;
    logic              rc_reqn_q, rc_reqn_d;
    logic              is_reconfn_q, is_reconfn_d;
    logic              rr_rstn_q, rr_rstn_d;
    logic              cfg_start_q, cfg_start_d;
    logic [RRID_W-1:0] cfg_rrid_q, cfg_rrid_d;

    // Saturating so a long ACK_TIMEOUT can never wrap back below the limit.
    assign ack_nxt = (ack_cnt_q == 16'hFFFF) ? ack_cnt_q : ack_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        ack_cnt_d    = ack_cnt_q;
        rst_cnt_d    = rst_cnt_q;
        cur_rrid_d   = cur_rrid_q;
        cfg_rrid_d   = cfg_rrid_q;
        rc_reqn_d    = rc_reqn_q;
        is_reconfn_d = is_reconfn_q;
        rr_rstn_d    = rr_rstn_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cfg_start_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cfg_rrid_d = req_rrid;
                    if (req_rrid == cur_rrid_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_QUIESCE;
                        ack_cnt_d = '0;
                        rc_reqn_d = 1'b0;
                    end
                end
            end
            S_QUIESCE: begin
                if (!rc_ackn) begin
                    state_d      = S_ISOLATE;
                    is_reconfn_d = 1'b0;
                end else begin
                    ack_cnt_d = ack_nxt;
                    if (ack_nxt >= ACK_LIM) begin
                        state_d   = S_ABORT;
                        rc_reqn_d = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end
            S_ISOLATE: begin
                state_d     = S_CONFIG;
                cfg_start_d = 1'b1;
                rr_rstn_d   = 1'b0;
            end
            S_CONFIG: begin
                if (cfg_done) begin
                    if (cfg_err) begin
                        // Bad image stays isolated and in reset until a later swap succeeds.
                        state_d   = S_ABORT_CFG;
                        rc_reqn_d = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        state_d    = S_RRRESET;
                        cur_rrid_d = cfg_rrid_q;
                        rst_cnt_d  = '0;
                    end
                end
            end
            S_RRRESET: begin
                if (rst_cnt_q == RST_LIM) begin
                    state_d      = S_RELEASE;
                    rr_rstn_d    = 1'b1;
                    is_reconfn_d = 1'b1;
                    rc_reqn_d    = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            S_RELEASE:   state_d = S_IDLE;
            S_ABORT:     state_d = S_IDLE;
            S_ABORT_CFG: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE) && !done_d && !err_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ack_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            cur_rrid_q   <= RRID_RST;
            rc_reqn_q    <= 1'b1;
            is_reconfn_q <= 1'b1;
            rr_rstn_q    <= 1'b1;
            cfg_start_q  <= 1'b0;
            cfg_rrid_q   <= '0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            cur_rrid_q   <= cur_rrid_d;
            rc_reqn_q    <= rc_reqn_d;
            is_reconfn_q <= is_reconfn_d;
            rr_rstn_q    <= rr_rstn_d;
            cfg_start_q  <= cfg_start_d;
            cfg_rrid_q   <= cfg_rrid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign cur_rrid   = cur_rrid_q;
    assign rc_reqn    = rc_reqn_q;
    assign is_reconfn = is_reconfn_q;
    assign rr_rstn    = rr_rstn_q;
    assign cfg_start  = cfg_start_q;
    assign cfg_rrid   = cfg_rrid_q;

endmodule

// File: tb/tb_rr_reconf_ctrl.sv
// Bench for rr_reconf_ctrl: scenario tasks plus a scoreboard of expected done/err and cfg_start events.
module tb_rr_reconf_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_rrid = 2'd0;
    logic       req_ready, done, err, busy;
    logic [1:0] cur_rrid;
    logic       rc_reqn;
    logic       rc_ackn = 1'b1;
    logic       is_reconfn, rr_rstn, cfg_start;
    logic [1:0] cfg_rrid;
    logic       cfg_done = 1'b0;
    logic       cfg_err = 1'b0;

    rr_reconf_ctrl #(
        .RRID_W(2), .INIT_RRID(0), .ACK_TIMEOUT(8), .RST_CYCLES(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_rrid(req_rrid), .req_ready(req_ready),
        .done(done), .err(err), .busy(busy), .cur_rrid(cur_rrid),
        .rc_reqn(rc_reqn), .rc_ackn(rc_ackn),
        .is_reconfn(is_reconfn), .rr_rstn(rr_rstn),
        .cfg_start(cfg_start), .cfg_rrid(cfg_rrid),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [1:0] rrid;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] cfg_q[$];
    exp_t       e_m;
    logic [1:0] c_m;
    int total = 0;
    int bad = 0;
    int n_done = 0, n_err = 0, n_start = 0;

    // Scoreboard: every done/err pulse and every cfg_start is matched against what the scenario queued.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (done === 1'b1 || err === 1'b1) begin
                if (done === 1'b1) n_done++;
                if (err === 1'b1) n_err++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_pulse: done=%0b err=%0b, required no pulse", done, err);
                end else begin
                    e_m = exp_q.pop_front();
                    if ({err, done, cur_rrid} !== {e_m.is_err, ~e_m.is_err, e_m.rrid}) begin
                        bad++;
                        $display("FAIL sb_result: err/done/cur_rrid=%0b/%0b/%0d, required %0b/%0b/%0d",
                                 err, done, cur_rrid, e_m.is_err, ~e_m.is_err, e_m.rrid);
                    end
                end
            end
            if (cfg_start === 1'b1) begin
                n_start++;
                total++;
                if (cfg_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_cfg_start: cfg_rrid=%0d, required no cfg_start", cfg_rrid);
                end else begin
                    c_m = cfg_q.pop_front();
                    if (cfg_rrid !== c_m) begin
                        bad++;
                        $display("FAIL sb_cfg_rrid: got %0d, required %0d", cfg_rrid, c_m);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] id, output bit ok);
        for (int i = 0; i < 100 && req_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        ok = (req_ready === 1'b1);
        req_valid = 1'b1;
        req_rrid  = id;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #12;
        total++;
        if ({req_ready, done, err, busy, cur_rrid, rc_reqn, is_reconfn, rr_rstn, cfg_start, cfg_rrid}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_values: got %b, required 100000111000",
                     {req_ready, done, err, busy, cur_rrid, rc_reqn, is_reconfn, rr_rstn, cfg_start, cfg_rrid});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_normal_swap;
        bit ok, win_ok;
        int n, s0, d0;
        s0 = n_start; d0 = n_done;
        exp_q.push_back(exp_t'({1'b0, 2'd2}));
        cfg_q.push_back(2'd2);
        do_req(2'd2, ok);
        total++; if (!ok) begin bad++; $display("FAIL norm_req_ready_wait: req_ready=%0b, required 1", req_ready); end
        @(negedge clk);
        total++;
        if ({busy, req_ready, rc_reqn, is_reconfn} !== 4'b1001) begin
            bad++; $display("FAIL norm_quiesce: busy/rdy/rc_reqn/is_reconfn=%b, required 1001", {busy, req_ready, rc_reqn, is_reconfn});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rc_ackn = 1'b0;
        @(posedge clk); #1;
        rc_ackn = 1'b1;
        @(negedge clk);
        total++;
        if ({is_reconfn, rc_reqn, cfg_start} !== 3'b000) begin
            bad++; $display("FAIL norm_isolate: is_reconfn/rc_reqn/cfg_start=%b, required 000", {is_reconfn, rc_reqn, cfg_start});
        end
        @(negedge clk);
        total++;
        if ({cfg_start, rr_rstn, is_reconfn, cfg_rrid} !== 5'b10010) begin
            bad++; $display("FAIL norm_cfg_start: start/rr_rstn/is_reconfn/cfg_rrid=%b, required 10010", {cfg_start, rr_rstn, is_reconfn, cfg_rrid});
        end
        win_ok = 1'b1;
        repeat (9) begin
            @(negedge clk);
            if ({is_reconfn, rr_rstn, cfg_start, busy} !== 4'b0001) win_ok = 1'b0;
        end
        total++; if (!win_ok) begin bad++; $display("FAIL norm_config_window: isolation/reset not held, got %b, required 0001", {is_reconfn, rr_rstn, cfg_start, busy}); end
        @(posedge clk); #1; cfg_done = 1'b1;
        @(posedge clk); #1; cfg_done = 1'b0;
        n = 0;
        @(negedge clk);
        while (rr_rstn === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== 4) begin bad++; $display("FAIL norm_rr_rst_len: got %0d cycles, required 4", n); end
        total++;
        if ({done, rr_rstn, is_reconfn, rc_reqn} !== 4'b1111) begin
            bad++; $display("FAIL norm_release: done/rr_rstn/is_reconfn/rc_reqn=%b, required 1111", {done, rr_rstn, is_reconfn, rc_reqn});
        end
        @(negedge clk); #1;
        total++;
        if ({req_ready, busy, done, cur_rrid} !== 5'b10010) begin
            bad++; $display("FAIL norm_idle_after: rdy/busy/done/cur_rrid=%b, required 10010", {req_ready, busy, done, cur_rrid});
        end
        total++;
        if ((n_start - s0) !== 1 || (n_done - d0) !== 1) begin
            bad++; $display("FAIL norm_counts: cfg_start=%0d done=%0d, required 1 and 1", n_start - s0, n_done - d0);
        end
    endtask

    task automatic test_same_id;
        bit ok, win_ok;
        int s0;
        s0 = n_start;
        exp_q.push_back(exp_t'({1'b0, 2'd2}));
        do_req(2'd2, ok);
        total++; if (!ok) begin bad++; $display("FAIL same_req_ready_wait: req_ready=%0b, required 1", req_ready); end
        @(negedge clk);
        total++;
        if ({done, busy, req_ready, rc_reqn, is_reconfn, cfg_start} !== 6'b100110) begin
            bad++; $display("FAIL same_done: done/busy/rdy/rc_reqn/is_reconfn/start=%b, required 100110",
                            {done, busy, req_ready, rc_reqn, is_reconfn, cfg_start});
        end
        win_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if ({rc_reqn, is_reconfn, cfg_start, busy, done, req_ready} !== 6'b110001) win_ok = 1'b0;
        end
        #1;
        total++; if (!win_ok || n_start !== s0) begin bad++; $display("FAIL same_quiet: toggled, cfg_start count %0d, required %0d", n_start, s0); end
    endtask

    task automatic test_ack_timeout;
        bit ok, win_ok;
        int n;
        exp_q.push_back(exp_t'({1'b1, 2'd2}));
        do_req(2'd1, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_req_ready_wait: req_ready=%0b, required 1", req_ready); end
        n = 0;
        win_ok = 1'b1;
        @(negedge clk);
        while (err !== 1'b1 && n < 50) begin
            if ({rc_reqn, is_reconfn} !== 2'b01) win_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        total++; if (n !== 8) begin bad++; $display("FAIL tmo_wait_len: err after %0d cycles, required 8", n); end
        total++; if (!win_ok) begin bad++; $display("FAIL tmo_quiesce_outputs: rc_reqn/is_reconfn not 0/1 while waiting, got %b", {rc_reqn, is_reconfn}); end
        total++;
        if ({err, rc_reqn, is_reconfn, cur_rrid} !== 5'b11110) begin
            bad++; $display("FAIL tmo_abort: err/rc_reqn/is_reconfn/cur_rrid=%b, required 11110", {err, rc_reqn, is_reconfn, cur_rrid});
        end
        @(negedge clk);
        total++; if ({req_ready, busy, err} !== 3'b100) begin bad++; $display("FAIL tmo_idle: rdy/busy/err=%b, required 100", {req_ready, busy, err}); end
    endtask

    task automatic test_cfg_error;
        bit ok, win_ok;
        int n;
        exp_q.push_back(exp_t'({1'b1, 2'd2}));
        cfg_q.push_back(2'd3);
        do_req(2'd3, ok);
        rc_ackn = 1'b0;
        @(posedge clk); #1;
        rc_ackn = 1'b1;
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL cerr_cfg_start_wait: cfg_start=%0b, required 1", cfg_start); end
        @(posedge clk); #1; cfg_done = 1'b1; cfg_err = 1'b1;
        @(posedge clk); #1; cfg_done = 1'b0; cfg_err = 1'b0;
        @(negedge clk);
        total++;
        if ({err, is_reconfn, rr_rstn, cur_rrid} !== 5'b10010) begin
            bad++; $display("FAIL cerr_abort: err/is_reconfn/rr_rstn/cur_rrid=%b, required 10010", {err, is_reconfn, rr_rstn, cur_rrid});
        end
        win_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({req_ready, busy, is_reconfn, rr_rstn} !== 4'b1000) win_ok = 1'b0;
        end
        total++; if (!win_ok) begin bad++; $display("FAIL cerr_isolation_held: rdy/busy/is_reconfn/rr_rstn=%b, required 1000", {req_ready, busy, is_reconfn, rr_rstn}); end
        exp_q.push_back(exp_t'({1'b0, 2'd1}));
        cfg_q.push_back(2'd1);
        do_req(2'd1, ok);
        rc_ackn = 1'b0;
        @(posedge clk); #1;
        rc_ackn = 1'b1;
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL cerr_retry_start_wait: cfg_start=%0b, required 1", cfg_start); end
        @(posedge clk); #1; cfg_done = 1'b1;
        @(posedge clk); #1; cfg_done = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        total++;
        if ({done, is_reconfn, rr_rstn, rc_reqn, cur_rrid} !== 6'b111101) begin
            bad++; $display("FAIL cerr_retry_release: done/is_reconfn/rr_rstn/rc_reqn/cur_rrid=%b, required 111101",
                            {done, is_reconfn, rr_rstn, rc_reqn, cur_rrid});
        end
    endtask

    task automatic test_robustness;
        bit ok, win_ok;
        int n, s0, e0;
        s0 = n_start; e0 = n_err;
        repeat (4) begin
            @(posedge clk); #1;
            cfg_done = 1'b1; rc_ackn = 1'b0; cfg_err = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        cfg_done = 1'b0; rc_ackn = 1'b1; cfg_err = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({req_ready, busy, rc_reqn, is_reconfn, rr_rstn, cur_rrid} !== 7'b1011101 || n_start !== s0) begin
            bad++; $display("FAIL rob_idle_noise: rdy/busy/rc_reqn/is_reconfn/rr_rstn/cur=%b starts=%0d, required 1011101 starts=%0d",
                            {req_ready, busy, rc_reqn, is_reconfn, rr_rstn, cur_rrid}, n_start, s0);
        end
        exp_q.push_back(exp_t'({1'b0, 2'd3}));
        cfg_q.push_back(2'd3);
        do_req(2'd3, ok);
        win_ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_rrid = 2'($urandom); cfg_done = 1'b1;
            @(negedge clk);
            if ({req_ready, busy, rc_reqn, is_reconfn, cfg_start} !== 5'b01010) win_ok = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; cfg_done = 1'b0; rc_ackn = 1'b0;
        @(posedge clk); #1;
        rc_ackn = 1'b1;
        total++; if (!win_ok) begin bad++; $display("FAIL rob_quiesce_noise: rdy/busy/rc_reqn/is_reconfn/start=%b, required 01010", {req_ready, busy, rc_reqn, is_reconfn, cfg_start}); end
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL rob_cfg_start_wait: cfg_start=%0b, required 1", cfg_start); end
        win_ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            req_valid = 1'b1; rc_ackn = 1'b0;
            @(negedge clk);
            if ({req_ready, busy, cfg_start, is_reconfn} !== 4'b0100) win_ok = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rc_ackn = 1'b1; cfg_done = 1'b1;
        @(posedge clk); #1; cfg_done = 1'b1; cfg_err = 1'b1;
        @(posedge clk); #1; cfg_done = 1'b0; cfg_err = 1'b0;
        total++; if (!win_ok) begin bad++; $display("FAIL rob_config_noise: rdy/busy/start/is_reconfn=%b, required 0100", {req_ready, busy, cfg_start, is_reconfn}); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        #1;
        total++;
        if ({done, cur_rrid, is_reconfn, rr_rstn} !== 5'b11111 || (n_start - s0) !== 1 || n_err !== e0) begin
            bad++; $display("FAIL rob_final: done/cur/is_reconfn/rr_rstn=%b starts=%0d errs=%0d, required 11111 starts=1 errs=0",
                            {done, cur_rrid, is_reconfn, rr_rstn}, n_start - s0, n_err - e0);
        end
    endtask

    task automatic test_reset_mid_config;
        bit ok;
        cfg_q.push_back(2'd2);
        do_req(2'd2, ok);
        rc_ackn = 1'b0;
        @(posedge clk); #1;
        rc_ackn = 1'b1;
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_cfg_start_wait: cfg_start=%0b, required 1", cfg_start); end
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({req_ready, done, err, busy, cur_rrid, rc_reqn, is_reconfn, rr_rstn, cfg_start, cfg_rrid}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL rst_async_mid_config: got %b, required 100000111000",
                     {req_ready, done, err, busy, cur_rrid, rc_reqn, is_reconfn, rr_rstn, cfg_start, cfg_rrid});
        end
        exp_q.delete();
        cfg_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready, busy, cur_rrid} !== 4'b1000) begin
            bad++; $display("FAIL rst_after_release: rdy/busy/cur_rrid=%b, required 1000", {req_ready, busy, cur_rrid});
        end
    endtask

    initial begin
        test_reset();
        test_normal_swap();
        test_same_id();
        test_ack_timeout();
        test_cfg_error();
        test_robustness();
        test_reset_mid_config();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || cfg_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d results and %0d cfg_starts never seen, required 0 and 0", exp_q.size(), cfg_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
